// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IR latch, valid/ack handoff to decode
// Optional range/alignment check on PC updates enabled by FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        fetch_start,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ack,
  input  logic        pc_update,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] instr_count,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        ir_valid_q, ir_valid_d;
  logic        fault_q, fault_d;

  logic        capture;
  logic        consume;
  logic        upd_en;
  logic        upd_bad;
  logic [31:0] new_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= NOP;
      ir_pc_q       <= 32'h0;
      ir_valid_q    <= 1'b0;
      instr_count_q <= 32'h0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      instr_count_q <= instr_count_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fetch_start && !fault_q) state_d = S_FETCH;
      S_FETCH: state_d = S_VALID;
      S_VALID: if (ir_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // PC updates are blocked during FETCH so ir_pc always names the captured word.
  always_comb begin
    capture = (state_q == S_FETCH);
    consume = (state_q == S_VALID) && ir_ack;
    upd_en  = pc_update && (state_q != S_FETCH);
  end

  always_comb begin
    new_pc = pc_src ? pc_target : (ir_pc_q + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
    upd_bad = (new_pc[1:0] != 2'b00) || (new_pc > 32'(IMEM_BYTES - 4));
`else
    upd_bad = 1'b0;
`endif
  end

  always_comb begin
    pc_d          = pc_q;
    fault_d       = fault_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    instr_count_d = instr_count_q;
    if (upd_en) begin
      if (upd_bad) fault_d = 1'b1;
      else         pc_d    = {new_pc[31:2], 2'b00};
    end
    if (capture) begin
      ir_d       = imem_instr;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
    end
    if (consume) begin
      ir_valid_d    = 1'b0;
      instr_count_d = instr_count_q + 32'd1;
    end
  end

  assign imem_pc     = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign instr_count = instr_count_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and random check of fetch_unit against a behavioural model
module tb_fetch_unit;

  localparam int unsigned IMEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        fetch_start = 1'b0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ack = 1'b0;
  logic        pc_update = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic [31:0] instr_count;
  logic        fetch_fault;

  logic [31:0] mem [0:1023];
  assign imem_instr = mem[imem_pc[11:2]];

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .fetch_start(fetch_start), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ack(ir_ack), .pc_update(pc_update), .pc_src(pc_src), .pc_target(pc_target),
    .instr_count(instr_count), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: architectural values plus two phase flags.
  logic [31:0] m_pc, m_ir, m_ir_pc, m_count;
  logic        m_valid, m_fetching, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic fs, input logic ack,
                            input logic upd, input logic src, input logic [31:0] tgt);
    logic [31:0] npc;
    logic        bad;
    if (r) begin
      m_pc = 32'h0; m_ir = 32'h13; m_ir_pc = 32'h0; m_count = 32'h0;
      m_valid = 1'b0; m_fetching = 1'b0; m_fault = 1'b0;
      return;
    end
    npc = src ? tgt : m_ir_pc + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
    bad = (npc % 4 != 0) || (longint'(npc) > longint'(IMEM_BYTES) - 4);
`else
    bad = 1'b0;
`endif
    if (m_fetching) begin
      m_ir = mem[m_pc[11:2]];
      m_ir_pc = m_pc;
      m_valid = 1'b1;
      m_fetching = 1'b0;
    end else begin
      if (upd) begin
        if (bad) m_fault = 1'b1;
        else     m_pc = npc & 32'hFFFF_FFFC;
      end
      if (m_valid) begin
        if (ack) begin
          m_valid = 1'b0;
          m_count = m_count + 32'd1;
        end
      end else if (fs && !m_fault) begin
        m_fetching = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic fs, input logic ack,
                      input logic upd, input logic src, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; fetch_start = fs; ir_ack = ack; pc_update = upd; pc_src = src; pc_target = tgt;
    model_edge(r, fs, ack, upd, src, tgt);
    @(posedge clk);
    #1;
    chk("imem_pc", imem_pc, m_pc);
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_ir_pc);
    chk("ir_valid", {31'h0, ir_valid}, {31'h0, m_valid});
    chk("instr_count", instr_count, m_count);
    chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
  endtask

  task automatic idle_cyc();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_2303;

    // Reset and quiet idle
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_ir", ir, 32'h13);
    chk("rst_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    for (int i = 0; i < 10; i++) idle_cyc();
    chk("idle_ir", ir, 32'h13);

    // Single fetch: ir_valid rises two edges after fetch_start sampled
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lat1_valid", {31'h0, ir_valid}, 32'h0);
    idle_cyc();
    chk("lat2_valid", {31'h0, ir_valid}, 32'h1);
    chk("single_ir", ir, 32'h0000_2303);
    chk("single_ir_pc", ir_pc, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("single_count", instr_count, 32'h1);

    // Sequential flow from reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle_cyc();
      chk("seq_ir_pc", ir_pc, 32'(i * 4));
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("seq_count", instr_count, 32'h4);

    // Branch redirect together with ack
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_cyc();
    chk("br_ir_pc", ir_pc, 32'h10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    chk("br_count", instr_count, 32'h5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_cyc();
    chk("br_next_ir_pc", ir_pc, 32'h0);

    // pc_update during FETCH is ignored
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    chk("fetch_upd_ir_pc", ir_pc, 32'h0);
    chk("fetch_upd_pc", imem_pc, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // ir_ack in IDLE leaves the count alone
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("idle_ack_count", instr_count, 32'h7);

`ifndef FETCH_ALIGN_CHECK_EN
    // ir_pc+4 wraps to zero
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_cyc();
    chk("wrap_ir_pc", ir_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc", imem_pc, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0107);
    chk("force_align_pc", imem_pc, 32'h0000_0104);
`endif

    // Reset in the middle of a fetch
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rstf_valid", {31'h0, ir_valid}, 32'h0);
    chk("rstf_pc", imem_pc, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h6);
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis_pc", imem_pc, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_cyc();
    chk("mis_blocked", {31'h0, ir_valid}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_clears_fault", {31'h0, fetch_fault}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1000);
    chk("range_fault", {31'h0, fetch_fault}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFC);
    chk("fault_sticky", {31'h0, fetch_fault}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        1: tgt = $urandom;
        2: tgt = 32'hFFFF_FFFC;
        default: tgt = 32'($urandom_range(0, 4100));
      endcase
      step(($urandom_range(0, 47) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), 1'($urandom), tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
